// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg
//   Shared types and constants for the key debounce block.
//   - key_fsm_e : per-key debounce state (IDLE, PRESS_CHK, DOWN, REL_CHK)
//   - MS_PER_S  : divides the clock frequency down to the 1 ms tick rate
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        DOWN      = 2'd2,
        REL_CHK   = 2'd3
    } key_fsm_e;

    localparam int unsigned MS_PER_S = 1000;

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if
//   Groups the key pins and the cleaned per-key outputs.
//   - key_n       : raw active-low button pins (driven by the board/master side)
//   - key_state   : debounced level, 1 = pressed
//   - key_press   : 1-cycle strobe on accepted press
//   - key_release : 1-cycle strobe on accepted release
//   - key_long    : 1-cycle strobe on long press
//   modport master : drives key_n, observes the outputs
//   modport slave  : the debouncer side
interface key_debounce_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_long;

    modport master (
        output key_n,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_n,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce_cell.sv
// key_debounce_cell
//   One key: 2-FF synchroniser, debounce FSM and tick counter.
//   Optional long-press detection is built when KEY_LONG_PRESS_EN is defined.
//   Ports:
//   - i_clk, i_rst : clock, synchronous active-high reset
//   - i_tick       : shared 1 ms tick (one cycle wide)
//   - i_key_n      : raw asynchronous pin, 0 = pressed
//   - o_state      : debounced level, 1 = pressed
//   - o_press      : 1-cycle strobe on accepted press
//   - o_release    : 1-cycle strobe on accepted release
//   - o_long       : 1-cycle strobe on long press (0 without KEY_LONG_PRESS_EN)
module key_debounce_cell
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int unsigned LONG_MS     = 1000
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_key_n,
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned CNT_MAX = (DEBOUNCE_MS > LONG_MS) ? DEBOUNCE_MS : LONG_MS;
`else
    localparam int unsigned CNT_MAX = DEBOUNCE_MS;
`endif
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_raw;
    key_fsm_e         r_st;
    key_fsm_e         w_st_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
`ifdef KEY_LONG_PRESS_EN
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] w_hold_inc;
    logic             r_long;
    logic             w_long_nxt;
`endif

    assign w_raw     = ~r_sync2;
    assign w_cnt_inc = r_cnt + CNT_W'(i_tick);
`ifdef KEY_LONG_PRESS_EN
    assign w_hold_inc = r_hold + CNT_W'(1);
`endif

    // State register (also holds the synchroniser and registered strobes)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_st      <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_hold    <= '0;
            r_long    <= 1'b0;
`endif
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_st      <= w_st_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
`ifdef KEY_LONG_PRESS_EN
            r_hold    <= w_hold_nxt;
            r_long    <= w_long_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_st_nxt      = r_st;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef KEY_LONG_PRESS_EN
        w_hold_nxt    = r_hold;
        w_long_nxt    = 1'b0;
`endif
        case (r_st)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_raw) begin
                    w_st_nxt = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!w_raw) begin
                    w_st_nxt  = IDLE;
                    w_cnt_nxt = '0;
                end else if (w_cnt_inc == CNT_W'(DEBOUNCE_MS)) begin
                    w_st_nxt    = DOWN;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
`ifdef KEY_LONG_PRESS_EN
                    w_hold_nxt  = '0;
`endif
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            DOWN: begin
                if (!w_raw) begin
                    w_st_nxt  = REL_CHK;
                    w_cnt_nxt = '0;
                end
`ifdef KEY_LONG_PRESS_EN
                // Hold count saturates at LONG_MS so the strobe fires once per hold
                else if (i_tick && (r_hold != CNT_W'(LONG_MS))) begin
                    w_hold_nxt = w_hold_inc;
                    w_long_nxt = (w_hold_inc == CNT_W'(LONG_MS));
                end
`endif
            end
            REL_CHK: begin
                // A bounce back to pressed resumes DOWN with the hold count intact
                if (w_raw) begin
                    w_st_nxt  = DOWN;
                    w_cnt_nxt = '0;
                end else if (w_cnt_inc == CNT_W'(DEBOUNCE_MS)) begin
                    w_st_nxt      = IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_st_nxt  = IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        o_state   = (r_st == DOWN) || (r_st == REL_CHK);
        o_press   = r_press;
        o_release = r_release;
`ifdef KEY_LONG_PRESS_EN
        o_long    = r_long;
`else
        o_long    = 1'b0;
`endif
    end

endmodule

// File: rtl/key_debounce.sv
// key_debounce
//   Reads NUM_KEYS active-low push-buttons; synchronises, debounces and edge-detects
//   each one. One shared 1 ms prescaler fans a tick out to one cell per key.
//   Optional feature macro: KEY_LONG_PRESS_EN (enables the key_long strobe).
//   Ports:
//   - i_clk : system clock (CLK_FREQ Hz)
//   - i_rst : synchronous active-high reset
//   - bus   : key_debounce_if.slave (key_n in; key_state/press/release/long out)
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 48_000_000,
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    key_debounce_if.slave         bus
);

    localparam int unsigned TICK_DIV = CLK_FREQ / MS_PER_S;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if ((NUM_KEYS < 1) || (NUM_KEYS > 16) || (DEBOUNCE_MS < 1) || (LONG_MS < 1) ||
        (TICK_DIV < 1)) begin : g_param_err
        $error("key_debounce: parameter out of range");
    end

    logic [PRE_W-1:0]    r_div;
    logic                w_tick;
    logic [NUM_KEYS-1:0] w_state;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;
    logic [NUM_KEYS-1:0] w_long;

    assign w_tick = (r_div == PRE_W'(TICK_DIV - 1));

    // Free-running 1 ms prescaler
    always_ff @(posedge i_clk) begin
        if (i_rst || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEBOUNCE_MS (DEBOUNCE_MS)
`ifdef KEY_LONG_PRESS_EN
            ,
            .LONG_MS     (LONG_MS)
`endif
        ) u_cell (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_tick    (w_tick),
            .i_key_n   (bus.key_n[i]),
            .o_state   (w_state[i]),
            .o_press   (w_press[i]),
            .o_release (w_release[i]),
            .o_long    (w_long[i])
        );
    end

    assign bus.key_state   = w_state;
    assign bus.key_press   = w_press;
    assign bus.key_release = w_release;
    assign bus.key_long    = w_long;

endmodule
